riscv_core_mul_div_ctrl: RTL

Sequencer between the execute stage and the M-extension mul/div unit. Accepts one request at a time over a valid/ready handshake and drives the unit's operands, control, isword and enable. It waits one cycle for the combinational multiplier or for done from the iterative divider, then holds the result until the writeback handshake completes. Also handles pipeline flush, RISC-V divide special cases and a divider watchdog.

---
 rtl/riscv_core_mdc_pkg.sv | 23 ++
 rtl/riscv_core_mdc_fastpath.sv | 46 ++++
 rtl/riscv_core_mul_div_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/riscv_core_mdc_pkg.sv
// Shared types and constants for the M-extension mul/div sequencer.
package riscv_core_mdc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        RESP = 2'd3
    } mdc_state_e;

    // control[2] selects the divider; control[1:0] is the op within the group
    localparam int DIV_SEL = 2;

    localparam logic [1:0] OP_MUL    = 2'd0;
    localparam logic [1:0] OP_MULH   = 2'd1;
    localparam logic [1:0] OP_MULHSU = 2'd2;
    localparam logic [1:0] OP_MULHU  = 2'd3;
    localparam logic [1:0] OP_DIV    = 2'd0;
    localparam logic [1:0] OP_DIVU   = 2'd1;
    localparam logic [1:0] OP_REM    = 2'd2;
    localparam logic [1:0] OP_REMU   = 2'd3;

endpackage

// File: rtl/riscv_core_mdc_fastpath.sv
// Combinational detect and result for RISC-V divide-by-zero and signed overflow.
// Only instantiated when RISCV_CORE_MDC_DIV_FASTPATH_EN is defined.
module riscv_core_mdc_fastpath
    import riscv_core_mdc_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic [2:0]      control,
    input  logic            isword,
    output logic            special,
    output logic [XLEN-1:0] result
);

    logic            b_zero_s;
    logic            a_min_s;
    logic            b_neg1_s;
    logic            is_signed_s;
    logic            is_rem_s;
    logic [XLEN-1:0] a_ext_s;

    // Special-case classification and architecturally defined results
    always_comb begin
        special     = 1'b0;
        result      = {XLEN{1'b0}};
        b_zero_s    = isword ? (src_b[31:0] == 32'h0000_0000) : (src_b == {XLEN{1'b0}});
        a_min_s     = isword ? (src_a[31:0] == 32'h8000_0000) : (src_a == {1'b1, {(XLEN-1){1'b0}}});
        b_neg1_s    = isword ? (src_b[31:0] == 32'hFFFF_FFFF) : (src_b == {XLEN{1'b1}});
        is_signed_s = (control[1:0] == OP_DIV) || (control[1:0] == OP_REM);
        is_rem_s    = (control[1:0] == OP_REM) || (control[1:0] == OP_REMU);
        a_ext_s     = isword ? {{(XLEN-32){src_a[31]}}, src_a[31:0]} : src_a;
        if (!control[DIV_SEL]) begin
            special = 1'b0;
        end else if (b_zero_s) begin
            special = 1'b1;
            result  = is_rem_s ? a_ext_s : {XLEN{1'b1}};
        end else if (is_signed_s && a_min_s && b_neg1_s) begin
            special = 1'b1;
            result  = is_rem_s ? {XLEN{1'b0}} : a_ext_s;
        end else begin
            special = 1'b0;
        end
    end

endmodule

// File: rtl/riscv_core_mul_div_ctrl.sv
// Sequencer between execute and the mul/div unit: handshake, wait, hold, flush, watchdog.
// Optional divide special-case bypass under RISCV_CORE_MDC_DIV_FASTPATH_EN.
module riscv_core_mul_div_ctrl
    import riscv_core_mdc_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int DIV_TIMEOUT = 80
) (
    input  logic            i_mdc_clk,
    input  logic            i_mdc_rst,
    input  logic            i_mdc_req_valid,
    output logic            o_mdc_req_ready,
    input  logic [3:0]      i_mdc_req_control,
    input  logic            i_mdc_req_isword,
    input  logic [XLEN-1:0] i_mdc_req_srcA,
    input  logic [XLEN-1:0] i_mdc_req_srcB,
    input  logic [4:0]      i_mdc_req_rd,
    input  logic            i_mdc_flush,
    output logic [XLEN-1:0] o_mdc_unit_srcA,
    output logic [XLEN-1:0] o_mdc_unit_srcB,
    output logic [3:0]      o_mdc_unit_control,
    output logic            o_mdc_unit_isword,
    output logic            o_mdc_unit_en,
    input  logic            i_mdc_unit_done,
    input  logic [XLEN-1:0] i_mdc_unit_result,
    output logic            o_mdc_rsp_valid,
    input  logic            i_mdc_rsp_ready,
    output logic [XLEN-1:0] o_mdc_rsp_result,
    output logic [4:0]      o_mdc_rsp_rd,
    output logic            o_mdc_rsp_err,
    output logic            o_mdc_busy
);

    localparam int               CNT_W    = $clog2(DIV_TIMEOUT + 1);
    // Compared before the increment so the abort fires as the count reaches DIV_TIMEOUT-1
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_TIMEOUT - 2);

    mdc_state_e       state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [XLEN-1:0]  result_r, result_s;
    logic             err_r, err_s;
    logic [XLEN-1:0]  src_a_r, src_b_r;
    logic [3:0]       control_r;
    logic             isword_r;
    logic [4:0]       rd_r;
    logic             rdy_en_r;
    logic             unit_en_r, rsp_valid_r, busy_r;
    logic             accept_s;
    logic             special_s;
    logic [XLEN-1:0]  special_res_s;

`ifdef RISCV_CORE_MDC_DIV_FASTPATH_EN
    riscv_core_mdc_fastpath #(.XLEN(XLEN)) u_fastpath (
        .src_a   (i_mdc_req_srcA),
        .src_b   (i_mdc_req_srcB),
        .control (i_mdc_req_control[2:0]),
        .isword  (i_mdc_req_isword),
        .special (special_s),
        .result  (special_res_s)
    );
`else
    assign special_s     = 1'b0;
    assign special_res_s = {XLEN{1'b0}};
`endif

    assign o_mdc_req_ready = rdy_en_r && (state_r == IDLE) && !i_mdc_flush;
    assign accept_s        = i_mdc_req_valid && o_mdc_req_ready;

    // Next-state, watchdog count and captured response
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        result_s = result_r;
        err_s    = err_r;
        if (i_mdc_flush && (state_r != IDLE)) begin
            state_s = IDLE;
            cnt_s   = {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_s = {CNT_W{1'b0}};
                    if (accept_s) begin
                        err_s = 1'b0;
                        if (!i_mdc_req_control[DIV_SEL]) begin
                            state_s = MUL;
                        end else if (special_s) begin
                            state_s  = RESP;
                            result_s = special_res_s;
                        end else begin
                            state_s = DIV;
                        end
                    end else begin
                        state_s = IDLE;
                    end
                end
                MUL: begin
                    state_s  = RESP;
                    result_s = i_mdc_unit_result;
                    err_s    = 1'b0;
                end
                DIV: begin
                    // done takes priority over a coincident watchdog expiry
                    if (i_mdc_unit_done) begin
                        state_s  = RESP;
                        result_s = i_mdc_unit_result;
                        err_s    = 1'b0;
                        cnt_s    = {CNT_W{1'b0}};
                    end else if (cnt_r == CNT_LAST) begin
                        state_s  = RESP;
                        result_s = {XLEN{1'b0}};
                        err_s    = 1'b1;
                        cnt_s    = {CNT_W{1'b0}};
                    end else begin
                        cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                RESP: begin
                    if (i_mdc_rsp_ready) begin
                        state_s = IDLE;
                    end else begin
                        state_s = RESP;
                    end
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // State, operand capture and registered outputs decoded from next state
    always_ff @(posedge i_mdc_clk) begin
        if (i_mdc_rst) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            result_r    <= {XLEN{1'b0}};
            err_r       <= 1'b0;
            src_a_r     <= {XLEN{1'b0}};
            src_b_r     <= {XLEN{1'b0}};
            control_r   <= 4'h0;
            isword_r    <= 1'b0;
            rd_r        <= 5'd0;
            rdy_en_r    <= 1'b0;
            unit_en_r   <= 1'b0;
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            result_r    <= result_s;
            err_r       <= err_s;
            rdy_en_r    <= 1'b1;
            unit_en_r   <= (state_s == MUL) || (state_s == DIV);
            rsp_valid_r <= (state_s == RESP);
            busy_r      <= (state_s != IDLE);
            if (accept_s) begin
                src_a_r   <= i_mdc_req_srcA;
                src_b_r   <= i_mdc_req_srcB;
                control_r <= i_mdc_req_control;
                isword_r  <= i_mdc_req_isword;
                rd_r      <= i_mdc_req_rd;
            end
        end
    end

    assign o_mdc_unit_srcA    = src_a_r;
    assign o_mdc_unit_srcB    = src_b_r;
    assign o_mdc_unit_control = control_r;
    assign o_mdc_unit_isword  = isword_r;
    assign o_mdc_unit_en      = unit_en_r;
    assign o_mdc_rsp_valid    = rsp_valid_r;
    assign o_mdc_rsp_result   = result_r;
    assign o_mdc_rsp_rd       = rd_r;
    assign o_mdc_rsp_err      = err_r;
    assign o_mdc_busy         = busy_r;

endmodule
